dht11_sensor_model: RTL
=======================

# dht11_sensor_model

Responder side of the DHT11 single-wire protocol: watches the open-drain data line for a host start pulse, then drives the sensor response and a 40-bit humidity/temperature/checksum frame with DHT11 bit timing. It serves as a synthesizable sensor emulator for closed-loop testing of the host reader on FPGA and in simulation, and includes a checksum-corruption control for exercising host error paths.

## Interface

- CLK_PER_US, default 50: clock cycles per microsecond; all phase durations below are multiplied by this value.
- START_MIN_US, default 18000: minimum host low time accepted as a start request.
- RESP_DELAY_US, default 30: wait after host release before the acknowledge begins.
- BIT0_HIGH_US, default 28: high time for a 0 bit.
- BIT1_HIGH_US, default 70: high time for a 1 bit.
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- data_in  in  1  sampled level of the shared data line (pulled up externally).
- data_oe  out  1  1 = pull the line low; 0 = release it. The pad is `data = data_oe ? 0 : z`.
- hum_int, hum_dec, temp_int, temp_dec  in  8 each  payload bytes.
- corrupt_chk  in  1  when set at snapshot time, the transmitted checksum is bitwise inverted.
- busy  out  1  high from start-pulse acceptance until the frame ends.
- frame_done  out  1  one-cycle pulse when the stop phase completes.

## Operation

- data_in passes through a 2-flop synchronizer. All host-side decisions use the synchronized value `ds`.
- States:
  - IDLE: on `ds`=0, go to HOST_LOW and clear the counter.
  - HOST_LOW: count cycles while `ds`=0. The counter saturates at START_MIN_US*CLK_PER_US.
    - On `ds`=1 with the count saturated: snapshot the payload, compute the checksum, assert busy, go to RESP_WAIT.
    - On `ds`=1 before saturation: return to IDLE with no response (short pulse ignored).
  - RESP_WAIT: released for RESP_DELAY_US, then ACK_LOW.
  - ACK_LOW: driven low for 80 µs, then ACK_HIGH.
  - ACK_HIGH: released for 80 µs, then BIT_LOW with bit index 39.
  - BIT_LOW: driven low for 50 µs, then BIT_HIGH.
  - BIT_HIGH: released for BIT1_HIGH_US if the current bit is 1, otherwise BIT0_HIGH_US.
    - If the bit index is 0, go to STOP_LOW.
    - Otherwise decrement the index and go to BIT_LOW.
  - STOP_LOW: driven low for 50 µs, then release, pulse frame_done, clear busy, go to IDLE.
- Frame order is MSB first: hum_int, hum_dec, temp_int, temp_dec, checksum. Frame bit 39 is hum_int[7].
- Checksum is (hum_int + hum_dec + temp_int + temp_dec) mod 256, computed as an 8-bit wraparound sum. It is inverted if corrupt_chk=1 at snapshot.
- Payload inputs and corrupt_chk are sampled only at the snapshot. Changes during a frame have no effect on it.
- From RESP_WAIT through STOP_LOW, `ds` is ignored, so a host driving low mid-frame does not restart the sequence.
- After returning to IDLE, a line still held low is treated as a new HOST_LOW. It is accepted only after a full START_MIN_US low count.

## Timing

- Reset values: data_oe=0, busy=0, frame_done=0, state IDLE, counters 0. Reset mid-frame releases the line immediately (asynchronous).
- data_oe is registered, and each phase holds its level for exactly duration*CLK_PER_US cycles.
- Latency from a data_in rising edge (host release) to the data_oe rise: 2 synchronizer cycles, plus 1 decision cycle, plus RESP_DELAY_US*CLK_PER_US cycles.
- busy rises in the cycle after the snapshot decision. It falls in the same cycle frame_done pulses, which is the first cycle of data_oe=0 after STOP_LOW.
- Frame duration from the ACK_LOW start to STOP_LOW end: 160 + 40*50 + sum of bit-high times + 50 µs.
- Counters are sized by $clog2 of the largest product (START_MIN_US*CLK_PER_US). No wrap is permitted.

## Test plan

All scenarios use CLK_PER_US=1, START_MIN_US=18, RESP_DELAY_US=30.

- Host low 20 cycles, then release, payload 0x37,0x00,0x19,0x00 -> data_oe rises 33 cycles after release. Ack is 80 low, 80 high. Decoded bytes 37 00 19 00 50. frame_done pulses once and busy falls with it.
- Host low 10 cycles (short) -> data_oe stays 0, busy stays 0, no frame_done.
- Payload 0xFF,0xFF,0xFF,0xFF -> checksum 0xFC. Every 1 bit has a high time of exactly 70 cycles; the checksum 0 bits are 28 cycles.
- corrupt_chk=1 at snapshot, payload 0x37,0x00,0x19,0x00 -> checksum byte 0xAF. The payload is changed to 0x00 mid-frame and the transmitted bytes are unchanged.
- Reset asserted during BIT_LOW of bit 20 -> data_oe=0 in the same cycle, busy=0, no frame_done. A subsequent valid start yields a complete frame.
- Host drives low for 5 cycles during ACK_HIGH -> frame completes unchanged. A start held low through frame end is accepted only after 18 further low cycles.

Source files
------------

// File: rtl/dht11_sensor_model_if.sv
// DHT11 single-wire bus bundle: line sense/drive, payload bytes and status.
// master = host/test side, slave = sensor emulator.
interface dht11_sensor_model_if;
  logic       data_in;
  logic       data_oe;
  logic [7:0] hum_int;
  logic [7:0] hum_dec;
  logic [7:0] temp_int;
  logic [7:0] temp_dec;
  logic       corrupt_chk;
  logic       busy;
  logic       frame_done;

  modport master (
    output data_in, hum_int, hum_dec,
    output temp_int, temp_dec, corrupt_chk,
    input  data_oe, busy, frame_done
  );

  modport slave (
    input  data_in, hum_int, hum_dec,
    input  temp_int, temp_dec, corrupt_chk,
    output data_oe, busy, frame_done
  );
endinterface

// File: rtl/dht11_sensor_model.sv
// DHT11 responder: detects host start pulse, sends ack and 40-bit frame.
// Ports: clk, reset (async, high), bus (slave: line, payload, status).
module dht11_sensor_model #(
  parameter int CLK_PER_US    = 50,
  parameter int START_MIN_US  = 18000,
  parameter int RESP_DELAY_US = 30,
  parameter int BIT0_HIGH_US  = 28,
  parameter int BIT1_HIGH_US  = 70
) (
  input logic                 clk,
  input logic                 reset,
  dht11_sensor_model_if.slave bus
);

  localparam int START_CYC = START_MIN_US * CLK_PER_US;
  localparam int RESP_CYC  = RESP_DELAY_US * CLK_PER_US;
  localparam int ACK_CYC   = 80 * CLK_PER_US;
  localparam int LOW_CYC   = 50 * CLK_PER_US;
  localparam int B0_CYC    = BIT0_HIGH_US * CLK_PER_US;
  localparam int B1_CYC    = BIT1_HIGH_US * CLK_PER_US;

  localparam int MA = (START_CYC > RESP_CYC) ? START_CYC : RESP_CYC;
  localparam int MB = (ACK_CYC > B1_CYC) ? ACK_CYC : B1_CYC;
  localparam int MC = (LOW_CYC > B0_CYC) ? LOW_CYC : B0_CYC;
  localparam int MD = (MB > MC) ? MB : MC;
  localparam int MX = (MA > MD) ? MA : MD;
  localparam int CW = $clog2(MX + 1);

  // HOST_LOW saturates at START_N; timed phases end at duration-1
  localparam logic [CW-1:0] START_N = CW'(START_CYC);
  localparam logic [CW-1:0] RESP_N  = CW'(RESP_CYC - 1);
  localparam logic [CW-1:0] ACK_N   = CW'(ACK_CYC - 1);
  localparam logic [CW-1:0] LOW_N   = CW'(LOW_CYC - 1);
  localparam logic [CW-1:0] B0_N    = CW'(B0_CYC - 1);
  localparam logic [CW-1:0] B1_N    = CW'(B1_CYC - 1);

  typedef enum logic [2:0] {
    IDLE, HOST_LOW, RESP_WAIT, ACK_LOW,
    ACK_HIGH, BIT_LOW, BIT_HIGH, STOP_LOW
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, term;
  logic [5:0]    idx_q, idx_d;
  logic [39:0]   frame_q, frame_d;
  logic          sync_q, ds_q;
  logic          oe_q, oe_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [7:0]    sum;
  logic          last;

  assign sum = bus.hum_int + bus.hum_dec
             + bus.temp_int + bus.temp_dec;

  always_comb begin
    term = START_N;
    unique case (state_q)
      RESP_WAIT:         term = RESP_N;
      ACK_LOW, ACK_HIGH: term = ACK_N;
      BIT_LOW, STOP_LOW: term = LOW_N;
      BIT_HIGH:          term = frame_q[idx_q] ? B1_N : B0_N;
      default:           term = START_N;
    endcase
  end

  assign last = (cnt_q == term);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    frame_d = frame_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!ds_q) begin
          state_d = HOST_LOW;
          cnt_d   = '0;
        end
      end
      HOST_LOW: begin
        if (!ds_q) begin
          if (!last) cnt_d = cnt_q + 1'b1;
        end else if (last) begin
          state_d = RESP_WAIT;
          cnt_d   = '0;
          frame_d = {bus.hum_int, bus.hum_dec,
                     bus.temp_int, bus.temp_dec,
                     sum ^ {8{bus.corrupt_chk}}};
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        if (!last) begin
          cnt_d = cnt_q + 1'b1;
        end else begin
          cnt_d = '0;
          unique case (state_q)
            RESP_WAIT: state_d = ACK_LOW;
            ACK_LOW:   state_d = ACK_HIGH;
            ACK_HIGH: begin
              state_d = BIT_LOW;
              idx_d   = 6'd39;
            end
            BIT_LOW:   state_d = BIT_HIGH;
            BIT_HIGH: begin
              if (idx_q == 6'd0) begin
                state_d = STOP_LOW;
              end else begin
                idx_d   = idx_q - 6'd1;
                state_d = BIT_LOW;
              end
            end
            STOP_LOW: begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
            default:   state_d = IDLE;
          endcase
        end
      end
    endcase
    oe_d   = (state_d == ACK_LOW) || (state_d == BIT_LOW)
          || (state_d == STOP_LOW);
    busy_d = (state_d != IDLE) && (state_d != HOST_LOW);
  end

  // sync flops reset to 1 so an idle pulled-up line is not seen as a start
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q  <= 1'b1;
      ds_q    <= 1'b1;
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      frame_q <= '0;
      oe_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      sync_q  <= bus.data_in;
      ds_q    <= sync_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      frame_q <= frame_d;
      oe_q    <= oe_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.data_oe    = oe_q;
  assign bus.busy       = busy_q;
  assign bus.frame_done = done_q;

endmodule
